// File: rtl/ram_split32_slave_if.sv
// MemSplit32 split-transaction bus bundle.
// Master drives req/we/addr/be/wdata; slave returns ack/resp/rdata.
interface MemSplit32;
    logic        req;
    logic        ack;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        resp;
    logic [31:0] rdata;

    modport Master (
        output req, we, addr, be, wdata,
        input  ack, resp, rdata
    );

    modport Slave (
        input  req, we, addr, be, wdata,
        output ack, resp, rdata
    );
endinterface

// File: rtl/ram_split32_slave.sv
// MemSplit32 responder on a word RAM: same-cycle ack, byte-enable
// writes, in-order fixed-latency reads with bounded outstanding count.
// Ports: clk_i, rst_i (sync, active-high), host (MemSplit32.Slave).
module ram_split32_slave #(
    parameter int MEM_SIZE_WORDS  = 1024,
    parameter int RD_LATENCY      = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    MemSplit32.Slave host
);

    localparam int IDX_W = $clog2(MEM_SIZE_WORDS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]           mem [MEM_SIZE_WORDS];
    logic [IDX_W-1:0]      idx;
    logic [RD_LATENCY-1:0] pipe_vld;
    logic [31:0]           pipe_data [RD_LATENCY];
    logic [CNT_W-1:0]      outstanding;
    logic                  resp_now;
    logic                  rd_ok;
    logic                  ack;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  unused_addr;

    assign idx         = host.addr[IDX_W+1:2];
    assign unused_addr = ^{host.addr[31:IDX_W+2], host.addr[1:0]};

    assign resp_now = pipe_vld[RD_LATENCY-1];
    // A response leaving this cycle frees a slot for a new read.
    assign rd_ok    = (outstanding < CNT_W'(MAX_OUTSTANDING)) || resp_now;
    assign ack      = !rst_i && host.req && (host.we || rd_ok);
    assign wr_fire  = ack && host.we;
    assign rd_fire  = ack && !host.we;

    assign host.ack   = ack;
    assign host.resp  = resp_now;
    // Stage data is zero whenever its valid bit is clear.
    assign host.rdata = pipe_data[RD_LATENCY-1];

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            for (int k = 0; k < 4; k++) begin
                if (host.be[k]) begin
                    mem[idx][8*k +: 8] <= host.wdata[8*k +: 8];
                end
            end
        end
    end

    // Read data is snapshotted at acceptance, so later writes
    // never disturb reads already in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= rd_fire;
            pipe_data[0] <= rd_fire ? mem[idx] : 32'h0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding <= '0;
        end else begin
            case ({rd_fire, resp_now})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_split32_slave.sv
// Scoreboard bench for ram_split32_slave: two instances
// (latency 2 / limit 2 and latency 3 / limit 1).
module tb_ram_split32_slave;

    logic clk;
    logic rst0;
    logic rst1;
    int   cyc;
    int   vectors;
    int   fails;

    logic [31:0] qd0 [$];
    int          qc0 [$];
    logic [31:0] qd1 [$];
    int          qc1 [$];

    MemSplit32 h0 ();
    MemSplit32 h1 ();

    ram_split32_slave #(
        .MEM_SIZE_WORDS (1024),
        .RD_LATENCY     (2),
        .MAX_OUTSTANDING(2)
    ) dut0 (
        .clk_i(clk),
        .rst_i(rst0),
        .host (h0)
    );

    ram_split32_slave #(
        .MEM_SIZE_WORDS (1024),
        .RD_LATENCY     (3),
        .MAX_OUTSTANDING(1)
    ) dut1 (
        .clk_i(clk),
        .rst_i(rst1),
        .host (h1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every response is popped and checked against the
    // scoreboard for data and arrival cycle; idle rdata must be 0.
    always @(negedge clk) begin
        vectors++;
        if (h0.resp) begin
            if (qd0.size() == 0) begin
                fails++;
                $display("FAIL resp0_unexpected got=%h cyc=%0d expected no resp", h0.rdata, cyc);
            end else begin
                logic [31:0] ed;
                int          ec;
                ed = qd0.pop_front();
                ec = qc0.pop_front();
                if (h0.rdata !== ed || cyc != ec) begin
                    fails++;
                    $display("FAIL resp0 got=%h@%0d expected %h@%0d", h0.rdata, cyc, ed, ec);
                end
            end
        end else if (h0.rdata !== 32'h0) begin
            fails++;
            $display("FAIL idle0_rdata got=%h expected 0", h0.rdata);
        end
        vectors++;
        if (h1.resp) begin
            if (qd1.size() == 0) begin
                fails++;
                $display("FAIL resp1_unexpected got=%h cyc=%0d expected no resp", h1.rdata, cyc);
            end else begin
                logic [31:0] ed;
                int          ec;
                ed = qd1.pop_front();
                ec = qc1.pop_front();
                if (h1.rdata !== ed || cyc != ec) begin
                    fails++;
                    $display("FAIL resp1 got=%h@%0d expected %h@%0d", h1.rdata, cyc, ed, ec);
                end
            end
        end else if (h1.rdata !== 32'h0) begin
            fails++;
            $display("FAIL idle1_rdata got=%h expected 0", h1.rdata);
        end
        vectors++;
        if (int'(dut0.outstanding) > 2 || int'(dut1.outstanding) > 1) begin
            fails++;
            $display("FAIL outstanding_bound got=%0d/%0d expected <=2/<=1",
                     dut0.outstanding, dut1.outstanding);
        end
    end

    task automatic drive(input int d, input logic r, input logic w,
                         input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] wd);
        if (d == 0) begin
            h0.req = r; h0.we = w; h0.addr = a; h0.be = b; h0.wdata = wd;
        end else begin
            h1.req = r; h1.we = w; h1.addr = a; h1.be = b; h1.wdata = wd;
        end
    endtask

    task automatic wr(input int d, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] b);
        logic ak;
        drive(d, 1'b1, 1'b1, a, b, wd);
        @(negedge clk);
        ak = (d == 0) ? h0.ack : h1.ack;
        vectors++;
        if (ak !== 1'b1) begin
            fails++;
            $display("FAIL wr_ack%0d addr=%h got=%b expected 1", d, a, ak);
        end
        @(posedge clk);
        #1;
        drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    // Holds a read until acked; checks the number of stall cycles
    // and, when track is set, queues the expected response.
    task automatic rd(input int d, input logic [31:0] a,
                      input logic [31:0] exp, input int stall,
                      input bit track);
        int   w;
        bit   got;
        logic ak;
        w   = 0;
        got = 0;
        drive(d, 1'b1, 1'b0, a, 4'h0, 32'h0);
        while (!got && w < 20) begin
            @(negedge clk);
            ak = (d == 0) ? h0.ack : h1.ack;
            if (ak === 1'b1) begin
                got = 1;
                if (track) begin
                    if (d == 0) begin
                        qd0.push_back(exp);
                        qc0.push_back(cyc + 2);
                    end else begin
                        qd1.push_back(exp);
                        qc1.push_back(cyc + 3);
                    end
                end
            end else begin
                w++;
                @(posedge clk);
                #1;
            end
        end
        vectors++;
        if (!got || w != stall) begin
            fails++;
            $display("FAIL rd_ack%0d addr=%h stalls=%0d acked=%0d expected stalls=%0d",
                     d, a, w, got, stall);
        end
        @(posedge clk);
        #1;
        drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        vectors = 0;
        fails   = 0;
        rst0    = 1'b1;
        rst1    = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
        drive(1, 1'b1, 1'b1, 32'h0, 4'hF, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (h0.ack !== 1'b0 || h1.ack !== 1'b0 || h0.resp !== 1'b0 ||
            h1.resp !== 1'b0 || dut0.outstanding != 0 || dut1.outstanding != 0) begin
            fails++;
            $display("FAIL reset_state ack=%b/%b resp=%b/%b out=%0d/%0d expected all 0",
                     h0.ack, h1.ack, h0.resp, h1.resp, dut0.outstanding, dut1.outstanding);
        end
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        idle(1);

        // Full-word write then read, then byte-enable merge.
        wr(0, 32'h40, 32'hDEADBEEF, 4'hF);
        rd(0, 32'h40, 32'hDEADBEEF, 0, 1);
        idle(3);
        wr(0, 32'h40, 32'h0000AA00, 4'h2);
        rd(0, 32'h40, 32'hDEADAAEF, 0, 1);
        wr(0, 32'h40, 32'hFFFFFFFF, 4'h0);
        rd(0, 32'h40, 32'hDEADAAEF, 0, 1);
        idle(3);

        // Back-to-back reads at full throughput.
        wr(0, 32'h0, 32'h11, 4'hF);
        wr(0, 32'h4, 32'h22, 4'hF);
        wr(0, 32'h8, 32'h33, 4'hF);
        wr(0, 32'hC, 32'h44, 4'hF);
        rd(0, 32'h0, 32'h11, 0, 1);
        rd(0, 32'h4, 32'h22, 0, 1);
        rd(0, 32'h8, 32'h33, 0, 1);
        rd(0, 32'hC, 32'h44, 0, 1);
        idle(3);

        // Reset while a read is in flight: it must vanish.
        wr(0, 32'h80, 32'h5A5A1234, 4'hF);
        rd(0, 32'h80, 32'h0, 0, 0);
        rst0 = 1'b1;
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        @(negedge clk);
        vectors++;
        if (dut0.outstanding != 0 || h0.resp !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_read out=%0d resp=%b expected 0/0",
                     dut0.outstanding, h0.resp);
        end
        idle(3);
        rd(0, 32'h80, 32'h5A5A1234, 0, 1);
        idle(3);

        // Aliasing (0x1000 -> word 0) and snapshot ordering.
        wr(0, 32'h1000, 32'h12345678, 4'hF);
        rd(0, 32'h0, 32'h12345678, 0, 1);
        idle(3);
        rd(0, 32'h3, 32'h12345678, 0, 1);
        wr(0, 32'h0, 32'hCAFEF00D, 4'hF);
        rd(0, 32'h0, 32'hCAFEF00D, 0, 1);
        idle(3);

        // Limit of one outstanding at latency 3.
        wr(1, 32'h0, 32'hA5A50000, 4'hF);
        rd(1, 32'h0, 32'hA5A50000, 0, 1);
        wr(1, 32'h14, 32'h00000077, 4'hF);
        rd(1, 32'h0, 32'hA5A50000, 1, 1);
        rd(1, 32'h0, 32'hA5A50000, 2, 1);
        rd(1, 32'h14, 32'h00000077, 2, 1);

        for (int i = 0; i < 20; i++) begin
            if (qd0.size() != 0 || qd1.size() != 0) @(posedge clk);
        end
        @(negedge clk);
        vectors++;
        if (qd0.size() != 0 || qd1.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d/%0d expected 0/0", qd0.size(), qd1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/ram_split32_slave.md
# ram_split32_slave

MemSplit32 responder that terminates a split-transaction bus port on a local word-organised RAM. It sits on a slave leg of the tile interconnect, for example as the data RAM behind the low-address slave port of the 2-master/3-slave arbiter. It accepts requests with a same-cycle combinational `ack`. Writes complete immediately with byte enables. Reads return in order through a fixed-latency pipeline, with a bounded number of outstanding reads.

## Interface
- `MEM_SIZE_WORDS`, default 1024: RAM depth in 32-bit words; must be a power of two. Index width `IDX_W = $clog2(MEM_SIZE_WORDS)`.
- `RD_LATENCY`, default 2, legal range 1..4: cycles from read acceptance to `resp`.
- `MAX_OUTSTANDING`, default 2, legal range 1..RD_LATENCY: maximum number of accepted reads not yet responded.
- `clk_i`, input, 1: clock. One clock domain.
- `rst_i`, input, 1: reset, synchronous and active-high.
- `host`, MemSplit32.Slave modport, made up of:
  - `host.req`, input, 1: request valid. The master holds it until `ack`.
  - `host.ack`, output, 1: request accepted this cycle.
  - `host.we`, input, 1: 1 = write, 0 = read.
  - `host.addr`, input, 32: byte address. Only bits `[IDX_W+1:2]` are used.
  - `host.be`, input, 4: write byte enables. Ignored on reads.
  - `host.wdata`, input, 32: write data.
  - `host.resp`, output, 1: read response strobe, one cycle per read. There is no backpressure.
  - `host.rdata`, output, 32: read data. Valid only while `resp` = 1; 0 otherwise.

## Operation
- **Word index:** `idx = host.addr[IDX_W+1:2]`. Upper address bits and `addr[1:0]` are ignored, so addresses alias modulo `MEM_SIZE_WORDS*4`.
- **Write acceptance:** a write (`req && we`) is always accepted.
  - `ack = 1` in the same cycle.
  - Each RAM byte `k` with `be[k]=1` takes `wdata[8k+7:8k]` at the clock edge.
  - `be = 0` is accepted and changes nothing.
- **Read acceptance:** a read (`req && !we`) is accepted when `outstanding < MAX_OUTSTANDING || resp_now`.
  - `resp_now` is the last pipeline stage's valid bit.
  - `ack` is combinational from `req`, `we`, `outstanding` and `resp_now`.
- **Read data capture:** an accepted read samples `mem[idx]` into pipeline stage 1 at the acceptance edge. Later writes do not alter data already in flight.
- **Read pipeline:** `RD_LATENCY` stages, each holding {valid, data}, shifting every cycle. The last stage drives `resp`/`rdata` directly from registers.
- **Outstanding counter:** width `$clog2(MAX_OUTSTANDING+1)`.
  - +1 on read accept.
  - −1 on `resp`.
  - Both in the same cycle leaves it unchanged.
  - It never exceeds `MAX_OUTSTANDING` and never underflows. The bench asserts both.
- **Ordering:** responses leave in acceptance order; no reordering.
- **Single port:** at most one request per cycle, so a read and a write never share a cycle.
- **Reset:**
  - Clears all pipeline valid bits and `outstanding`.
  - `resp = 0` and `rdata = 0` from the first cycle after the reset edge.
  - In-flight reads are dropped with no `resp`.
  - RAM contents are not reset.
  - `ack` stays combinational. During reset assertion, `ack` = 0; requests are not accepted.

## Timing
- **Write:**
  - Accepted in cycle N; data is visible to a read accepted in cycle N+1.
  - Read-after-write to the same word in consecutive cycles returns the new data.
- **Read:** accepted in cycle N → `resp = 1` with data in cycle N+RD_LATENCY, for exactly one cycle.
- **Throughput:**
  - With `MAX_OUTSTANDING = RD_LATENCY`: one read per cycle sustained.
  - With `MAX_OUTSTANDING = 1`: one read per `RD_LATENCY` cycles. The next read is accepted in the same cycle as the previous `resp`.
- **Stall:** a read blocked by the limit sees `ack = 0`. The master holds `req`/`addr`, and the read is accepted on the first cycle the condition holds.
- **Mixed traffic:** writes are never stalled, even when reads are at the limit.
- **Reset values:** `ack` = 0 (while `rst_i`=1), `resp` = 0, `rdata` = 0, `outstanding` = 0.

## Test plan
- **Full-word write/read:**
  - Stimulus: RD_LATENCY=2. Write addr 0x40 = 0xDEADBEEF, be=0xF; read 0x40 in the next cycle.
  - Required: `ack` in both cycles; `resp` exactly 2 cycles after the read `ack`, with rdata 0xDEADBEEF; rdata = 0 in all other cycles.
- **Byte-enable write:**
  - Stimulus: after the above, write 0x40 with wdata 0x0000AA00, be=0x2; then read 0x40.
  - Required: rdata 0xDEADAAEF.
- **Back-to-back reads:**
  - Stimulus: RD_LATENCY=2, MAX_OUTSTANDING=2. Preload words 0..3 = 0x11,0x22,0x33,0x44; issue 4 reads in consecutive cycles.
  - Required: `ack` every cycle; `resp` in 4 consecutive cycles with 0x11,0x22,0x33,0x44 in order.
- **Outstanding limit:**
  - Stimulus: RD_LATENCY=3, MAX_OUTSTANDING=1. Hold read `req` to word 0 continuously.
  - Required: `ack` at cycles N, N+3, N+6; `resp` at N+3, N+6, N+9; a write issued at N+1 is acked immediately.
- **Reset mid-read:**
  - Stimulus: accept a read at N, assert `rst_i` at N+1 for one cycle.
  - Required: no `resp` ever appears for that read; outstanding = 0; a subsequent read returns the pre-reset RAM value.
- **Aliasing and snapshot:**
  - Stimulus: MEM_SIZE_WORDS=1024. Write 0x1000 = 0x12345678, read 0x0. Then read 0x0 and write 0x0 = 0xCAFEF00D in the next cycle.
  - Required: the first read returns 0x12345678; the second read still returns 0x12345678 (snapshot), and a following read returns 0xCAFEF00D.
